// File: rtl/tail_light_monitor.sv
// tail_light_monitor: receive-side checker for the six-lamp turn-signal bus.
// Samples y every clock, decodes mode/step, checks each transition against the
// left, right and hazard sequences, latches the first violation and keeps
// saturating counts of completed sequences.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   y[5:0]     in   lamp vector {LC,LB,LA,RA,RB,RC}
//   clr        in   synchronous clear of fault/counters, returns to SYNC
//   mode[1:0]  out  00 idle, 01 left, 10 right, 11 hazard
//   step[1:0]  out  lamps lit in current half (3 for hazard)
//   synced     out  all-off has been seen and checking is active
//   fault      out  sticky violation flag
//   fault_code out  000 none, 001 illegal pattern, 010 illegal edge, 011 stall
//   left_cnt / right_cnt / haz_cnt  out  completed-sequence counters
module tail_light_monitor #(
  parameter int unsigned CW        = 8,
  parameter int unsigned STALL_MAX = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    y,
  input  logic          clr,
  output logic [1:0]    mode,
  output logic [1:0]    step,
  output logic          synced,
  output logic          fault,
  output logic [2:0]    fault_code,
  output logic [CW-1:0] left_cnt,
  output logic [CW-1:0] right_cnt,
  output logic [CW-1:0] haz_cnt
);

  typedef enum logic [3:0] {
    S_SYNC, S_OFF, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HZ
  } state_t;

  localparam int unsigned SW = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX);

  localparam logic [2:0] FC_NONE  = 3'b000;
  localparam logic [2:0] FC_PAT   = 3'b001;
  localparam logic [2:0] FC_EDGE  = 3'b010;
  localparam logic [2:0] FC_STALL = 3'b011;

  state_t          r_state, w_state;
  logic [SW-1:0]   r_stall, w_stall;
  logic            r_fault, w_fault;
  logic [2:0]      r_code, w_code;
  logic [CW-1:0]   r_lcnt, w_lcnt;
  logic [CW-1:0]   r_rcnt, w_rcnt;
  logic [CW-1:0]   r_hcnt, w_hcnt;
  logic            r_cnt_ok, w_cnt_ok;
  logic [1:0]      r_mode, w_mode;
  logic [1:0]      r_step, w_step;
  logic            r_synced, w_synced;

  state_t          w_pat;
  logic            w_pat_ok;
  logic            w_viol;
  logic [2:0]      w_vcode;

  // Legal successor of a checking state (same-state hold handled separately).
  function automatic logic legal_edge(input state_t from, input state_t to);
    case (from)
      S_OFF:                return (to == S_L1) || (to == S_R1) || (to == S_HZ);
      S_L1:                 return to == S_L2;
      S_L2:                 return to == S_L3;
      S_R1:                 return to == S_R2;
      S_R2:                 return to == S_R3;
      S_L3, S_R3, S_HZ:     return to == S_OFF;
      default:              return 1'b0;
    endcase
  endfunction

  // {mode, step} shown for a state; SYNC and OFF both read as idle.
  function automatic logic [3:0] mode_step(input state_t s);
    case (s)
      S_L1:    return 4'b01_01;
      S_L2:    return 4'b01_10;
      S_L3:    return 4'b01_11;
      S_R1:    return 4'b10_01;
      S_R2:    return 4'b10_10;
      S_R3:    return 4'b10_11;
      S_HZ:    return 4'b11_11;
      default: return 4'b00_00;
    endcase
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Pattern decode; illegal values map to SYNC with w_pat_ok low.
  always_comb begin
    w_pat    = S_SYNC;
    w_pat_ok = 1'b1;
    case (y)
      6'b000000: w_pat = S_OFF;
      6'b001000: w_pat = S_L1;
      6'b011000: w_pat = S_L2;
      6'b111000: w_pat = S_L3;
      6'b000100: w_pat = S_R1;
      6'b000110: w_pat = S_R2;
      6'b000111: w_pat = S_R3;
      6'b111111: w_pat = S_HZ;
      default:   w_pat_ok = 1'b0;
    endcase
  end

  // Next-state, checking and counting.
  always_comb begin
    w_state  = r_state;
    w_stall  = r_stall;
    w_fault  = r_fault;
    w_code   = r_code;
    w_lcnt   = r_lcnt;
    w_rcnt   = r_rcnt;
    w_hcnt   = r_hcnt;
    w_cnt_ok = r_cnt_ok;
    w_viol   = 1'b0;
    w_vcode  = FC_NONE;

    if (clr) begin
      w_state  = S_SYNC;
      w_stall  = '0;
      w_fault  = 1'b0;
      w_code   = FC_NONE;
      w_lcnt   = '0;
      w_rcnt   = '0;
      w_hcnt   = '0;
      w_cnt_ok = 1'b0;
    end else if (r_state == S_SYNC) begin
      if (w_pat_ok && (w_pat == S_OFF)) begin
        w_state  = S_OFF;
        w_stall  = '0;
        w_cnt_ok = 1'b1;
      end
    end else begin
      if (!w_pat_ok) begin
        w_viol  = 1'b1;
        w_vcode = FC_PAT;
        w_state = S_SYNC;
        w_stall = '0;
      end else if (w_pat == r_state) begin
        // OFF may idle forever; lit patterns may only hold STALL_MAX extra cycles.
        if (r_state != S_OFF) begin
          if (r_stall < STALL_LIM) begin
            w_stall = r_stall + SW'(1);
          end else begin
            w_viol  = 1'b1;
            w_vcode = FC_STALL;
          end
        end
      end else if (legal_edge(r_state, w_pat)) begin
        w_state = w_pat;
        w_stall = '0;
        if (r_cnt_ok) begin
          case (r_state)
            S_L3:    w_lcnt = sat_inc(r_lcnt);
            S_R3:    w_rcnt = sat_inc(r_rcnt);
            S_HZ:    w_hcnt = sat_inc(r_hcnt);
            default: ;
          endcase
        end
      end else begin
        w_viol  = 1'b1;
        w_vcode = FC_EDGE;
        w_state = w_pat;
        w_stall = '0;
      end

      // After a violation, counting waits until the monitor is back in OFF,
      // so a sequence that started out of step is never credited.
      if (w_viol) begin
        w_cnt_ok = 1'b0;
        if (!r_fault) begin
          w_fault = 1'b1;
          w_code  = w_vcode;
        end
      end else if (w_state == S_OFF) begin
        w_cnt_ok = 1'b1;
      end
    end

    {w_mode, w_step} = mode_step(w_state);
    w_synced         = (w_state != S_SYNC);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_SYNC;
      r_stall  <= '0;
      r_fault  <= 1'b0;
      r_code   <= FC_NONE;
      r_lcnt   <= '0;
      r_rcnt   <= '0;
      r_hcnt   <= '0;
      r_cnt_ok <= 1'b0;
      r_mode   <= 2'b00;
      r_step   <= 2'b00;
      r_synced <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_stall  <= w_stall;
      r_fault  <= w_fault;
      r_code   <= w_code;
      r_lcnt   <= w_lcnt;
      r_rcnt   <= w_rcnt;
      r_hcnt   <= w_hcnt;
      r_cnt_ok <= w_cnt_ok;
      r_mode   <= w_mode;
      r_step   <= w_step;
      r_synced <= w_synced;
    end
  end

  assign mode       = r_mode;
  assign step       = r_step;
  assign synced     = r_synced;
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign left_cnt   = r_lcnt;
  assign right_cnt  = r_rcnt;
  assign haz_cnt    = r_hcnt;

endmodule

// File: tb/tb_tail_light_monitor.sv
// Testbench for tail_light_monitor (CW=2, STALL_MAX=1): scenario tasks push
// expected output snapshots to a queue as stimulus is driven and pop/compare
// them once the DUT has registered the sample.
module tb_tail_light_monitor;

  localparam int unsigned CW = 2;

  logic          clk;
  logic          reset;
  logic [5:0]    y;
  logic          clr;
  logic [1:0]    mode;
  logic [1:0]    step;
  logic          synced;
  logic          fault;
  logic [2:0]    fault_code;
  logic [CW-1:0] left_cnt;
  logic [CW-1:0] right_cnt;
  logic [CW-1:0] haz_cnt;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] step;
    logic       synced;
    logic       fault;
    logic [2:0] code;
    logic [1:0] lc;
    logic [1:0] rc;
    logic [1:0] hc;
  } obs_t;

  typedef struct packed {
    logic [5:0] y;
    logic       clr;
    obs_t       e;
  } step_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [5:0] P_OFF = 6'b000000;
  localparam logic [5:0] P_L1  = 6'b001000;
  localparam logic [5:0] P_L2  = 6'b011000;
  localparam logic [5:0] P_L3  = 6'b111000;
  localparam logic [5:0] P_R1  = 6'b000100;
  localparam logic [5:0] P_R2  = 6'b000110;
  localparam logic [5:0] P_R3  = 6'b000111;
  localparam logic [5:0] P_HZ  = 6'b111111;

  tail_light_monitor #(.CW(CW), .STALL_MAX(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .y          (y),
    .clr        (clr),
    .mode       (mode),
    .step       (step),
    .synced     (synced),
    .fault      (fault),
    .fault_code (fault_code),
    .left_cnt   (left_cnt),
    .right_cnt  (right_cnt),
    .haz_cnt    (haz_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input int m, input int s, input int sy, input int f,
                              input int fc, input int l, input int r, input int h);
    obs_t o;
    o.mode   = 2'(m);
    o.step   = 2'(s);
    o.synced = 1'(sy);
    o.fault  = 1'(f);
    o.code   = 3'(fc);
    o.lc     = 2'(l);
    o.rc     = 2'(r);
    o.hc     = 2'(h);
    return o;
  endfunction

  function automatic step_t st(input logic [5:0] yv, input logic c, input obs_t e);
    step_t s;
    s.y   = yv;
    s.clr = c;
    s.e   = e;
    return s;
  endfunction

  function automatic obs_t sample();
    return {mode, step, synced, fault, fault_code, left_cnt, right_cnt, haz_cnt};
  endfunction

  // Drive one sample, then settle 1 time unit past the capturing edge.
  task automatic cyc(input logic [5:0] yv, input logic c);
    y   = yv;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s[4];
    obs_t  got, want;
    obs_t  z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    y     = P_OFF;
    clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(z);
    got  = sample();
    want = exp_q.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=%h", got, want);
    end
    reset = 1'b1;
    // Lit pattern while unsynced is ignored; sync only on the OFF sample.
    s = '{st(P_L1, 1'b0, z), st(P_L1, 1'b0, z), st(P_L1, 1'b0, z),
          st(P_OFF, 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 0))};
    foreach (s[i]) begin
      exp_q.push_back(s[i].e);
      cyc(s[i].y, s[i].clr);
      got  = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL sync[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_left_right();
    step_t s[9];
    obs_t  got, want;
    s = '{st(P_OFF, 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 0)),
          st(P_L1,  1'b0, mk(1, 1, 1, 0, 0, 0, 0, 0)),
          st(P_L2,  1'b0, mk(1, 2, 1, 0, 0, 0, 0, 0)),
          st(P_L3,  1'b0, mk(1, 3, 1, 0, 0, 0, 0, 0)),
          st(P_OFF, 1'b0, mk(0, 0, 1, 0, 0, 1, 0, 0)),
          st(P_R1,  1'b0, mk(2, 1, 1, 0, 0, 1, 0, 0)),
          st(P_R2,  1'b0, mk(2, 2, 1, 0, 0, 1, 0, 0)),
          st(P_R3,  1'b0, mk(2, 3, 1, 0, 0, 1, 0, 0)),
          st(P_OFF, 1'b0, mk(0, 0, 1, 0, 0, 1, 1, 0))};
    foreach (s[i]) begin
      exp_q.push_back(s[i].e);
      cyc(s[i].y, s[i].clr);
      got  = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL left_right[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_hazard();
    step_t s[6];
    obs_t  got, want;
    s = '{st(P_HZ,  1'b0, mk(3, 3, 1, 0, 0, 1, 1, 0)),
          st(P_OFF, 1'b0, mk(0, 0, 1, 0, 0, 1, 1, 1)),
          st(P_HZ,  1'b0, mk(3, 3, 1, 0, 0, 1, 1, 1)),
          st(P_OFF, 1'b0, mk(0, 0, 1, 0, 0, 1, 1, 2)),
          st(P_HZ,  1'b0, mk(3, 3, 1, 0, 0, 1, 1, 2)),
          st(P_OFF, 1'b0, mk(0, 0, 1, 0, 0, 1, 1, 3))};
    foreach (s[i]) begin
      exp_q.push_back(s[i].e);
      cyc(s[i].y, s[i].clr);
      got  = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL hazard[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_fault_sticky();
    step_t s[5];
    obs_t  got, want;
    s = '{st(P_OFF,      1'b0, mk(0, 0, 1, 0, 0, 1, 1, 3)),
          st(P_L1,       1'b0, mk(1, 1, 1, 0, 0, 1, 1, 3)),
          st(P_L3,       1'b0, mk(1, 3, 1, 1, 2, 1, 1, 3)),
          st(6'b101010,  1'b0, mk(0, 0, 0, 1, 2, 1, 1, 3)),
          st(P_OFF,      1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0))};
    foreach (s[i]) begin
      exp_q.push_back(s[i].e);
      cyc(s[i].y, s[i].clr);
      got  = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL fault_sticky[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_stall();
    step_t s[17];
    obs_t  got, want;
    obs_t  z, s0;
    z  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    s0 = mk(0, 0, 1, 0, 0, 0, 0, 0);
    s = '{st(P_OFF, 1'b0, s0),
          st(P_R1,  1'b0, mk(2, 1, 1, 0, 0, 0, 0, 0)),
          st(P_R1,  1'b0, mk(2, 1, 1, 0, 0, 0, 0, 0)),
          st(P_R2,  1'b0, mk(2, 2, 1, 0, 0, 0, 0, 0)),
          st(P_R2,  1'b0, mk(2, 2, 1, 0, 0, 0, 0, 0)),
          st(P_R3,  1'b0, mk(2, 3, 1, 0, 0, 0, 0, 0)),
          st(P_R3,  1'b0, mk(2, 3, 1, 0, 0, 0, 0, 0)),
          st(P_OFF, 1'b0, mk(0, 0, 1, 0, 0, 0, 1, 0)),
          st(P_R1,  1'b0, mk(2, 1, 1, 0, 0, 0, 1, 0)),
          st(P_R1,  1'b0, mk(2, 1, 1, 0, 0, 0, 1, 0)),
          st(P_R1,  1'b0, mk(2, 1, 1, 1, 3, 0, 1, 0)),
          st(P_OFF, 1'b1, z),
          st(P_OFF, 1'b0, s0),
          st(6'b010001, 1'b0, mk(0, 0, 0, 1, 1, 0, 0, 0)),
          st(P_OFF, 1'b1, z),
          st(P_OFF, 1'b0, s0),
          st(6'b010001, 1'b1, z)};
    foreach (s[i]) begin
      exp_q.push_back(s[i].e);
      cyc(s[i].y, s[i].clr);
      got  = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL stall_pattern[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_saturation();
    step_t s[4];
    obs_t  got, want;
    int    lp, ln;
    exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    cyc(P_OFF, 1'b0);
    got  = sample();
    want = exp_q.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL sat_sync got=%h want=%h", got, want);
    end
    for (int k = 1; k <= 5; k++) begin
      lp = (k - 1 > 3) ? 3 : k - 1;
      ln = (k > 3) ? 3 : k;
      s = '{st(P_L1,  1'b0, mk(1, 1, 1, 0, 0, lp, 0, 0)),
            st(P_L2,  1'b0, mk(1, 2, 1, 0, 0, lp, 0, 0)),
            st(P_L3,  1'b0, mk(1, 3, 1, 0, 0, lp, 0, 0)),
            st(P_OFF, 1'b0, mk(0, 0, 1, 0, 0, ln, 0, 0))};
      foreach (s[i]) begin
        exp_q.push_back(s[i].e);
        cyc(s[i].y, s[i].clr);
        got  = sample();
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL saturate[%0d.%0d] got=%h want=%h", k, i, got, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t s[6];
    obs_t  got, want;
    obs_t  z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    s = '{st(P_L1,  1'b0, mk(1, 1, 1, 0, 0, 3, 0, 0)),
          st(P_L2,  1'b0, mk(1, 2, 1, 0, 0, 3, 0, 0)),
          st(P_OFF, 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 0)),
          st(P_L1,  1'b0, mk(1, 1, 1, 0, 0, 0, 0, 0)),
          st(P_L2,  1'b0, mk(1, 2, 1, 0, 0, 0, 0, 0)),
          st(P_L3,  1'b0, mk(1, 3, 1, 0, 0, 0, 0, 0))};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(s[i].e);
      cyc(s[i].y, s[i].clr);
      got  = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mid_pre[%0d] got=%h want=%h", i, got, want);
      end
    end
    // Asynchronous reset between clock edges, while the bus still shows L2.
    #2;
    reset = 1'b0;
    exp_q.push_back(z);
    #1;
    got  = sample();
    want = exp_q.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL mid_async_reset got=%h want=%h", got, want);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 2; i < 6; i++) begin
      exp_q.push_back(s[i].e);
      cyc(s[i].y, s[i].clr);
      got  = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mid_post[%0d] got=%h want=%h", i, got, want);
      end
    end
    exp_q.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0));
    cyc(P_OFF, 1'b0);
    got  = sample();
    want = exp_q.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL mid_recount got=%h want=%h", got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired n_tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_left_right();
    test_hazard();
    test_fault_sticky();
    test_stall();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
